// File: rtl/tpu_host_pkg.sv
// -----------------------------------------------------------------------------
// tpu_host_pkg
// Shared definitions for the TPU host controller slice:
//   - default bus widths (buffer index, A/B word, C word)
//   - controller FSM state encoding
//   - quad_words(): word count of a matrix packed four elements per word
// Optional feature macro used by the top: TPU_HOST_PERF_CNT_EN
// -----------------------------------------------------------------------------
package tpu_host_pkg;

    localparam int unsigned HOST_ADDR_W  = 16;
    localparam int unsigned HOST_DATA_W  = 32;
    localparam int unsigned HOST_CDATA_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_LAUNCH  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_DRAIN   = 3'd6
    } host_state_e;

    // rows * ceil(cols / 4), 16-bit unsigned
    function automatic logic [15:0] quad_words(input logic [7:0] rows, input logic [7:0] cols);
        logic [15:0] groups;
        groups = (16'(cols) + 16'd3) >> 2;
        return 16'(rows) * groups;
    endfunction

endpackage

// File: rtl/tpu_host_ctrl_if.sv
// -----------------------------------------------------------------------------
// tpu_host_ctrl_if
// Fabric-side bus of the TPU host controller.
//   cmd_*  : command handshake carrying K/M/N
//   s_*    : 32-bit input stream (A words then B words)
//   m_*    : 128-bit output stream (C words)
// Modports: master = system/stream fabric, slave = tpu_host_ctrl.
// -----------------------------------------------------------------------------
interface tpu_host_ctrl_if
    import tpu_host_pkg::*;
#(
    parameter int unsigned DATA_W  = HOST_DATA_W,
    parameter int unsigned CDATA_W = HOST_CDATA_W
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_k;
    logic [7:0]         cmd_m;
    logic [7:0]         cmd_n;

    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;

    logic               m_valid;
    logic               m_ready;
    logic [CDATA_W-1:0] m_data;

    modport master (
        output cmd_valid, cmd_k, cmd_m, cmd_n, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_data
    );

    modport slave (
        input  cmd_valid, cmd_k, cmd_m, cmd_n, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_data
    );
endinterface

// File: rtl/tpu_host_skid.sv
// -----------------------------------------------------------------------------
// tpu_host_skid
// Two-entry CDATA_W skid buffer between the C-buffer read port and the output
// stream. Output data/valid come straight from storage, so they hold while the
// consumer stalls. Contents are flushed by the asynchronous reset.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid_i/in_ready_o    write side handshake, in_data_i write data
//   out_valid_o/out_ready_i  read side handshake, out_data_o head word (0 when empty)
//   count_o                  current occupancy (0..2)
// -----------------------------------------------------------------------------
module tpu_host_skid
    import tpu_host_pkg::*;
#(
    parameter int unsigned CDATA_W = HOST_CDATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [CDATA_W-1:0] in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [CDATA_W-1:0] out_data_o,
    output logic [1:0]         count_o
);
    logic [1:0][CDATA_W-1:0] mem_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic                    push;
    logic                    pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/tpu_host_ctrl.sv
// -----------------------------------------------------------------------------
// tpu_host_ctrl
// Host-side driver for the TPU core: loads the A/B buffers from the input
// stream, pulses in_valid with K/M/N, waits for busy to rise and fall, then
// drains the C buffer to the output stream through a two-entry skid buffer.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   bus (tpu_host_ctrl_if.slave)       cmd / s_* / m_* handshakes
//   in_valid, K, M, N, busy            TPU launch and status
//   A_wr_en, A_index, A_data_in        A buffer write port
//   B_wr_en, B_index, B_data_in        B buffer write port
//   C_index, C_data_out                C buffer read port (1-cycle latency)
//   done, err                          completion / rejected-command pulses
//   perf_cycles                        TPU compute cycle count
// Optional feature: define TPU_HOST_PERF_CNT_EN to build the perf counter;
// otherwise perf_cycles is tied to 0.
// -----------------------------------------------------------------------------
module tpu_host_ctrl
    import tpu_host_pkg::*;
#(
    parameter int unsigned ADDR_W  = HOST_ADDR_W,
    parameter int unsigned DATA_W  = HOST_DATA_W,
    parameter int unsigned CDATA_W = HOST_CDATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    tpu_host_ctrl_if.slave     bus,
    output logic               in_valid,
    output logic [7:0]         K,
    output logic [7:0]         M,
    output logic [7:0]         N,
    input  logic               busy,
    output logic               A_wr_en,
    output logic [ADDR_W-1:0]  A_index,
    output logic [DATA_W-1:0]  A_data_in,
    output logic               B_wr_en,
    output logic [ADDR_W-1:0]  B_index,
    output logic [DATA_W-1:0]  B_data_in,
    output logic [ADDR_W-1:0]  C_index,
    input  logic [CDATA_W-1:0] C_data_out,
    output logic               done,
    output logic               err,
    output logic [31:0]        perf_cycles
);
    host_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q;
    logic [ADDR_W-1:0]  out_cnt_q;
    logic [7:0]         k_q, m_q, n_q;
    logic               cmd_ready_q, s_ready_q, in_valid_q, done_q, err_q;
    logic               inflight_q, issued_all_q;

    logic [ADDR_W-1:0]  a_last, b_last, c_last;
    logic               cmd_fire, cmd_bad, s_fire, pop, rd_fire;

    logic               skid_valid, skid_in_ready;
    logic [1:0]         skid_count;
    logic [CDATA_W-1:0] skid_data;

    assign a_last = ADDR_W'(quad_words(k_q, m_q)) - ADDR_W'(1);
    assign b_last = ADDR_W'(quad_words(k_q, n_q)) - ADDR_W'(1);
    assign c_last = ADDR_W'(quad_words(m_q, n_q)) - ADDR_W'(1);

    assign cmd_fire = bus.cmd_valid && cmd_ready_q;
    assign cmd_bad  = (bus.cmd_k == '0) || (bus.cmd_m == '0) || (bus.cmd_n == '0);
    assign s_fire   = bus.s_valid && s_ready_q;
    assign pop      = skid_valid && bus.m_ready;

    // Issue a C read only if the word is guaranteed a skid slot when it
    // returns next cycle: occupancy + in-flight, less this cycle's pop, < 2.
    assign rd_fire = (state_q == ST_DRAIN) && !issued_all_q &&
                     (({1'b0, skid_count} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, pop}));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_fire && !cmd_bad)                        state_d = ST_LOAD_A;
            ST_LOAD_A:  if (s_fire && (cnt_q == a_last))                 state_d = ST_LOAD_B;
            ST_LOAD_B:  if (s_fire && (cnt_q == b_last))                 state_d = ST_LAUNCH;
            ST_LAUNCH:                                                   state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (busy)                                        state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!busy)                                       state_d = ST_DRAIN;
            ST_DRAIN:   if (pop && (out_cnt_q == c_last))                state_d = ST_IDLE;
            default:                                                     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with the state they belong to; cmd_ready stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_cnt_q    <= '0;
            k_q          <= '0;
            m_q          <= '0;
            n_q          <= '0;
            cmd_ready_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            in_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            inflight_q   <= 1'b0;
            issued_all_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            s_ready_q   <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
            in_valid_q  <= (state_d == ST_LAUNCH);
            err_q       <= cmd_fire && cmd_bad;
            done_q      <= pop && (out_cnt_q == c_last);
            inflight_q  <= rd_fire;
            if (cmd_fire) begin
                k_q <= bus.cmd_k;
                m_q <= bus.cmd_m;
                n_q <= bus.cmd_n;
            end
            if (state_d != state_q) begin
                cnt_q        <= '0;
                out_cnt_q    <= '0;
                issued_all_q <= 1'b0;
            end else begin
                if (s_fire) begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                end
                // Read index parks on the last word instead of running past it
                if (rd_fire) begin
                    if (cnt_q == c_last) issued_all_q <= 1'b1;
                    else                 cnt_q        <= cnt_q + ADDR_W'(1);
                end
                if (pop) begin
                    out_cnt_q <= out_cnt_q + ADDR_W'(1);
                end
            end
        end
    end

    tpu_host_skid #(
        .CDATA_W(CDATA_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (inflight_q),
        .in_ready_o (skid_in_ready),
        .in_data_i  (C_data_out),
        .out_valid_o(skid_valid),
        .out_ready_i(bus.m_ready),
        .out_data_o (skid_data),
        .count_o    (skid_count)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = skid_valid;
    assign bus.m_data    = skid_data;

    assign in_valid  = in_valid_q;
    assign K         = k_q;
    assign M         = m_q;
    assign N         = n_q;
    assign done      = done_q;
    assign err       = err_q;

    assign A_wr_en   = s_fire && (state_q == ST_LOAD_A);
    assign A_index   = (state_q == ST_LOAD_A) ? cnt_q : '0;
    assign A_data_in = A_wr_en ? bus.s_data : '0;
    assign B_wr_en   = s_fire && (state_q == ST_LOAD_B);
    assign B_index   = (state_q == ST_LOAD_B) ? cnt_q : '0;
    assign B_data_in = B_wr_en ? bus.s_data : '0;
    assign C_index   = (state_q == ST_DRAIN) ? cnt_q : '0;

    // The in-flight word always has a slot; this gate only blocks on overflow
    logic unused_ok;
    assign unused_ok = skid_in_ready;

`ifdef TPU_HOST_PERF_CNT_EN
    // Counts every cycle spent in WAIT_HI/WAIT_LO: first cycle after the
    // in_valid pulse through the cycle busy is seen low.
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (cmd_fire) begin
            perf_q <= '0;
        end else if (((state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO)) && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
